jala_control_fsm: RTL

- Multicycle control unit for the 16-bit stack CPU.
- Consumes the instruction register and the ALU zero flag.
- Drives every control input of the stage-5 datapath: PC, MSP and RSP incrementers, the two-port memory stage, and the ValA/ValB/IR latches. It also drives the ALU opcode and the Res latch enable.
- It is the initiator side of the datapath control interface.

---
 rtl/jala_ctrl_pkg.sv | 68 ++++++
 rtl/jala_control_fsm_if.sv | 42 ++++
 rtl/jala_ctrl_decode.sv | 67 ++++++
 rtl/jala_control_fsm.sv | 105 ++++++++++
 4 files changed

// File: rtl/jala_ctrl_pkg.sv
// Shared encodings for the JALA stack-CPU control unit: opcodes, FSM states,
// datapath mux selects and the decoded control word.
package jala_ctrl_pkg;

  localparam int OPW  = 4;
  localparam int IMMW = 12;

  localparam logic [OPW-1:0] OP_NOP   = 4'h0;
  localparam logic [OPW-1:0] OP_PUSHI = 4'h1;
  localparam logic [OPW-1:0] OP_POP   = 4'h2;
  localparam logic [OPW-1:0] OP_ADD   = 4'h3;
  localparam logic [OPW-1:0] OP_SUB   = 4'h4;
  localparam logic [OPW-1:0] OP_AND   = 4'h5;
  localparam logic [OPW-1:0] OP_JMP   = 4'h6;
  localparam logic [OPW-1:0] OP_BRZ   = 4'h7;
  localparam logic [OPW-1:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_PUSHI, S_POPDEC, S_READA, S_POPDEC2,
    S_READB, S_ALU, S_PUSHR, S_JUMP, S_BRZ, S_HALT
  } state_e;

  localparam logic [1:0] DST1_PC     = 2'd0;
  localparam logic [1:0] DST1_MSP    = 2'd1;
  localparam logic [1:0] DST2_MSP    = 2'd0;
  localparam logic [1:0] DST2_RSP    = 2'd1;
  localparam logic [1:0] MDATA_PC    = 2'd0;
  localparam logic [1:0] MDATA_RES   = 2'd1;
  localparam logic [1:0] MDATA_ZEIMM = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_AND   = 2'd2;
  localparam logic [1:0] ALU_PASSA = 2'd3;

  localparam logic PCSRC_ADDER = 1'b0;
  localparam logic PCSRC_VALA  = 1'b1;
  localparam logic PCADD_ONE   = 1'b0;
  localparam logic PCADD_SEXT  = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       pc_add;
    logic       msp_write;
    logic       msp_pop;
    logic       rsp_write;
    logic       rsp_pop;
    logic       vala_write;
    logic       valb_write;
    logic       ir_write;
    logic       res_write;
    logic       mem_read1;
    logic       mem_read2;
    logic       mem_write1;
    logic       mem_write2;
    logic [1:0] mem_dst1;
    logic [1:0] mem_dst2;
    logic [1:0] mem_data;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  function automatic logic is_illegal(input logic [OPW-1:0] op);
    return (op >= 4'h8) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/jala_control_fsm_if.sv
// Control interface between the JALA control FSM (master) and the datapath
// (slave). IllegalOp exists only when JALA_ILLEGAL_TRAP_EN is defined.
interface jala_control_fsm_if;
  logic [15:0] IR;
  logic        Zero;
  logic        PCWrite, PCSource, PCAdd;
  logic        MSPWrite, MSPPop, RSPWrite, RSPPop;
  logic        PCRegReset, MSPRegReset, RSPRegReset;
  logic        ValAWrite, ValBWrite, IRWrite, ResWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2, MemData, ALUOp;
  logic        Halted;
`ifdef JALA_ILLEGAL_TRAP_EN
  logic        IllegalOp;
`endif

  modport master (
    input  IR, Zero,
    output PCWrite, PCSource, PCAdd, MSPWrite, MSPPop, RSPWrite, RSPPop,
    output PCRegReset, MSPRegReset, RSPRegReset,
    output ValAWrite, ValBWrite, IRWrite, ResWrite,
    output MemRead1, MemRead2, MemWrite1, MemWrite2,
    output MemDst1, MemDst2, MemData, ALUOp,
    output Halted
`ifdef JALA_ILLEGAL_TRAP_EN
    , output IllegalOp
`endif
  );

  modport slave (
    output IR, Zero,
    input  PCWrite, PCSource, PCAdd, MSPWrite, MSPPop, RSPWrite, RSPPop,
    input  PCRegReset, MSPRegReset, RSPRegReset,
    input  ValAWrite, ValBWrite, IRWrite, ResWrite,
    input  MemRead1, MemRead2, MemWrite1, MemWrite2,
    input  MemDst1, MemDst2, MemData, ALUOp,
    input  Halted
`ifdef JALA_ILLEGAL_TRAP_EN
    , input IllegalOp
`endif
  );
endinterface

// File: rtl/jala_ctrl_decode.sv
// Combinational state/opcode/Zero to control-word mapping. Moore outputs
// except PCWrite in BRZ, which follows Zero.
module jala_ctrl_decode
  import jala_ctrl_pkg::*;
(
  input  state_e         state_i,
  input  logic [OPW-1:0] op_i,
  input  logic           zero_i,
  output ctrl_t          ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read1 = 1'b1;
        ctrl_o.mem_dst1  = DST1_PC;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_ADDER;
        ctrl_o.pc_add    = PCADD_ONE;
      end
      S_PUSHI, S_PUSHR: begin
        ctrl_o.mem_write2 = 1'b1;
        ctrl_o.mem_dst2   = DST2_MSP;
        ctrl_o.mem_data   = (state_i == S_PUSHI) ? MDATA_ZEIMM : MDATA_RES;
        ctrl_o.msp_write  = 1'b1;
        ctrl_o.msp_pop    = 1'b0;
      end
      S_POPDEC, S_POPDEC2: begin
        ctrl_o.msp_write = 1'b1;
        ctrl_o.msp_pop   = 1'b1;
      end
      S_READA: begin
        ctrl_o.mem_read1  = 1'b1;
        ctrl_o.mem_dst1   = DST1_MSP;
        ctrl_o.vala_write = 1'b1;
      end
      S_READB: begin
        ctrl_o.mem_read2  = 1'b1;
        ctrl_o.mem_dst2   = DST2_MSP;
        ctrl_o.valb_write = 1'b1;
      end
      S_ALU: begin
        ctrl_o.res_write = 1'b1;
        case (op_i)
          OP_SUB:  ctrl_o.alu_op = ALU_SUB;
          OP_AND:  ctrl_o.alu_op = ALU_AND;
          OP_BRZ:  ctrl_o.alu_op = ALU_PASSA;
          default: ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_VALA;
      end
      S_BRZ: begin
        ctrl_o.pc_write  = zero_i;
        ctrl_o.pc_source = PCSRC_ADDER;
        ctrl_o.pc_add    = PCADD_SEXT;
      end
      S_HALT:  ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/jala_control_fsm.sv
// Multicycle control FSM for the JALA 16-bit stack CPU. Optional illegal
// opcode trap enabled by defining JALA_ILLEGAL_TRAP_EN.
module jala_control_fsm
  import jala_ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               RegReset,
  jala_control_fsm_if.master bus
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op;
  ctrl_t          dec, ctrl;

  assign op = bus.IR[15:12];

  jala_ctrl_decode u_decode (
    .state_i (state_q),
    .op_i    (op),
    .zero_i  (bus.Zero),
    .ctrl_o  (dec)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_NOP:   state_d = S_FETCH;
          OP_PUSHI: state_d = S_PUSHI;
          OP_POP, OP_ADD, OP_SUB, OP_AND, OP_JMP, OP_BRZ: state_d = S_POPDEC;
          OP_HALT:  state_d = S_HALT;
`ifdef JALA_ILLEGAL_TRAP_EN
          default:  state_d = S_HALT;
`else
          default:  state_d = S_FETCH;
`endif
        endcase
      end
      S_PUSHI:   state_d = S_FETCH;
      S_POPDEC:  state_d = S_READA;
      S_READA: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: state_d = S_POPDEC2;
          OP_JMP:  state_d = S_JUMP;
          OP_BRZ:  state_d = S_ALU;
          default: state_d = S_FETCH;
        endcase
      end
      S_POPDEC2: state_d = S_READB;
      S_READB:   state_d = S_ALU;
      S_ALU:     state_d = (op == OP_BRZ) ? S_BRZ : S_PUSHR;
      S_PUSHR, S_JUMP, S_BRZ: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RegReset) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

`ifdef JALA_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | ((state_q == S_DECODE) && is_illegal(op));

  always_ff @(posedge CLK) begin
    if (RegReset) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end

  assign bus.IllegalOp = illegal_q;
`endif

  // Reset silences every strobe in the same cycle, abandoning any instruction.
  assign ctrl = RegReset ? '0 : dec;

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.PCAdd       = ctrl.pc_add;
  assign bus.MSPWrite    = ctrl.msp_write;
  assign bus.MSPPop      = ctrl.msp_pop;
  assign bus.RSPWrite    = ctrl.rsp_write;
  assign bus.RSPPop      = ctrl.rsp_pop;
  assign bus.ValAWrite   = ctrl.vala_write;
  assign bus.ValBWrite   = ctrl.valb_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.ResWrite    = ctrl.res_write;
  assign bus.MemRead1    = ctrl.mem_read1;
  assign bus.MemRead2    = ctrl.mem_read2;
  assign bus.MemWrite1   = ctrl.mem_write1;
  assign bus.MemWrite2   = ctrl.mem_write2;
  assign bus.MemDst1     = ctrl.mem_dst1;
  assign bus.MemDst2     = ctrl.mem_dst2;
  assign bus.MemData     = ctrl.mem_data;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.Halted      = ctrl.halted;
  assign bus.PCRegReset  = RegReset;
  assign bus.MSPRegReset = RegReset;
  assign bus.RSPRegReset = RegReset;

endmodule
